pcileech_pcie_int_arb: RTL and testbench

//  Shares the single PCIe-core interrupt port (cfg_interrupt / cfg_interrupt_rdy) between the
//  per-function interrupt sources of the multi-function config block. Latches per-function requests,

---
 rtl/pcileech_pcie_int_arb.sv | 183 ++++++++++++++++++
 tb/tb_pcileech_pcie_int_arb.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_pcie_int_arb.sv
// Round-robin arbiter sharing the PCIe core interrupt port between per-function requesters.
// Optional MSI path compiled in with `define PCIE_INT_ARB_MSI_EN; default build is legacy INTx only.
module pcileech_pcie_int_arb #(
    parameter int NUM_FUNCTIONS  = 2,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_pcie,
    input  logic                     rst,
    input  logic                     int_enable,
    input  logic [NUM_FUNCTIONS-1:0] func_int_en,
    input  logic [NUM_FUNCTIONS-1:0] int_req,
    output logic [NUM_FUNCTIONS-1:0] int_ack,
    output logic                     cfg_interrupt,
    output logic                     cfg_interrupt_assert,
    output logic [7:0]               cfg_interrupt_di,
    input  logic                     cfg_interrupt_rdy,
    input  logic                     cfg_interrupt_msienable,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int MAX_CNT = (HOLDOFF_CYCLES > TIMEOUT_CYCLES) ? HOLDOFF_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    PTR_RST   = 3'(NUM_FUNCTIONS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLD,
        ST_DEASSERT,
        ST_GAP
`ifdef PCIE_INT_ARB_MSI_EN
        , ST_SEND
`endif
    } state_t;

    state_t                     state;
    logic [2:0]                 ptr;
    logic [2:0]                 cur_idx;
    logic [CW-1:0]              cnt;
    logic [NUM_FUNCTIONS-1:0]   pending;
    logic [NUM_FUNCTIONS-1:0]   eligible;
    logic [2*NUM_FUNCTIONS-1:0] elig2;
    logic [NUM_FUNCTIONS-1:0]   elig_rot;
    logic [4:0]                 rr_sum;
    logic                       grant_valid;
    logic [2:0]                 grant_idx;
    logic                       ack_fire;
    logic [NUM_FUNCTIONS-1:0]   ack_mask;

`ifndef PCIE_INT_ARB_MSI_EN
    logic unused_msienable;
    assign unused_msienable = cfg_interrupt_msienable;
`endif

    assign eligible = pending & func_int_en & {NUM_FUNCTIONS{int_enable}};
    assign busy     = (state != ST_IDLE);

    // Rotate the eligible vector so bit 0 is the function just after the last grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        rr_sum      = '0;
        elig2       = {eligible, eligible};
        elig_rot    = NUM_FUNCTIONS'(elig2 >> (4'(ptr) + 4'd1));
        for (int i = 0; i < NUM_FUNCTIONS; i++) begin
            if (!grant_valid && elig_rot[i]) begin
                grant_valid = 1'b1;
                rr_sum      = 5'(ptr) + 5'd1 + 5'(i);
                if (rr_sum >= 5'(NUM_FUNCTIONS)) rr_sum = rr_sum - 5'(NUM_FUNCTIONS);
                grant_idx   = 3'(rr_sum);
            end
        end
    end

`ifdef PCIE_INT_ARB_MSI_EN
    assign ack_fire = cfg_interrupt && cfg_interrupt_rdy && (state == ST_ASSERT || state == ST_SEND);
`else
    assign ack_fire = cfg_interrupt && cfg_interrupt_rdy && (state == ST_ASSERT);
`endif
    assign ack_mask = ack_fire ? (NUM_FUNCTIONS'(1) << cur_idx) : '0;

    // A new request in the same cycle as its ack wins, giving one more delivery.
    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~ack_mask) | int_req;
    end

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            ptr                  <= PTR_RST;
            cur_idx              <= '0;
            cnt                  <= '0;
            int_ack              <= '0;
            cfg_interrupt        <= 1'b0;
            cfg_interrupt_assert <= 1'b0;
            cfg_interrupt_di     <= '0;
            timeout_err          <= 1'b0;
        end else begin
            int_ack     <= ack_mask;
            timeout_err <= 1'b0;
            cnt         <= (cnt == '1) ? cnt : cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        ptr              <= grant_idx;
                        cur_idx          <= grant_idx;
                        cnt              <= '0;
                        cfg_interrupt    <= 1'b1;
                        cfg_interrupt_di <= {5'b0, grant_idx};
`ifdef PCIE_INT_ARB_MSI_EN
                        if (cfg_interrupt_msienable) begin
                            state                <= ST_SEND;
                            cfg_interrupt_assert <= 1'b0;
                        end else
`endif
                        begin
                            state                <= ST_ASSERT;
                            cfg_interrupt_assert <= 1'b1;
                        end
                    end
                end
                ST_ASSERT: begin
                    if (cfg_interrupt_rdy) begin
                        cfg_interrupt <= 1'b0;
                        state         <= ST_HOLD;
                        cnt           <= '0;
                    end else if (cnt == TMO_LAST) begin
                        cfg_interrupt <= 1'b0;
                        timeout_err   <= 1'b1;
                        state         <= ST_GAP;
                        cnt           <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cfg_interrupt        <= 1'b1;
                        cfg_interrupt_assert <= 1'b0;
                        state                <= ST_DEASSERT;
                        cnt                  <= '0;
                    end
                end
                ST_DEASSERT: begin
                    if (cfg_interrupt_rdy) begin
                        cfg_interrupt <= 1'b0;
                        state         <= ST_GAP;
                        cnt           <= '0;
                    end else if (cnt == TMO_LAST) begin
                        cfg_interrupt <= 1'b0;
                        timeout_err   <= 1'b1;
                        state         <= ST_GAP;
                        cnt           <= '0;
                    end
                end
`ifdef PCIE_INT_ARB_MSI_EN
                ST_SEND: begin
                    if (cfg_interrupt_rdy || cnt == TMO_LAST) begin
                        cfg_interrupt <= 1'b0;
                        timeout_err   <= !cfg_interrupt_rdy;
                        state         <= ST_GAP;
                        cnt           <= '0;
                    end
                end
`endif
                ST_GAP: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_pcie_int_arb.sv
// Self-checking bench for pcileech_pcie_int_arb: scoreboard of expected core handshakes and acks.
// Exercises the MSI path when PCIE_INT_ARB_MSI_EN is defined, otherwise checks it stays legacy.
module tb_pcileech_pcie_int_arb;

    localparam int NF = 2;

    logic          clk_pcie = 1'b0;
    logic          rst;
    logic          int_enable;
    logic [NF-1:0] func_int_en;
    logic [NF-1:0] int_req;
    logic [NF-1:0] int_ack;
    logic          cfg_interrupt;
    logic          cfg_interrupt_assert;
    logic [7:0]    cfg_interrupt_di;
    logic          cfg_interrupt_rdy;
    logic          cfg_interrupt_msienable;
    logic          busy;
    logic          timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    bit auto_rdy  = 1'b0;
    bit rdy_never = 1'b0;
    int rdy_delay = 1;
    int wait_cnt  = 0;

    logic [8:0] exp_hs[$];
    logic [8:0] obs_hs[$];
    int         exp_ack[$];
    int         obs_ack[$];

    pcileech_pcie_int_arb #(
        .NUM_FUNCTIONS (NF),
        .HOLDOFF_CYCLES(16),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk_pcie               (clk_pcie),
        .rst                    (rst),
        .int_enable             (int_enable),
        .func_int_en            (func_int_en),
        .int_req                (int_req),
        .int_ack                (int_ack),
        .cfg_interrupt          (cfg_interrupt),
        .cfg_interrupt_assert   (cfg_interrupt_assert),
        .cfg_interrupt_di       (cfg_interrupt_di),
        .cfg_interrupt_rdy      (cfg_interrupt_rdy),
        .cfg_interrupt_msienable(cfg_interrupt_msienable),
        .busy                   (busy),
        .timeout_err            (timeout_err)
    );

    always #5 clk_pcie = ~clk_pcie;

    // Core model: answers rdy a few cycles into each request and logs accepted handshakes and acks.
    initial begin
        cfg_interrupt_rdy = 1'b0;
        forever begin
            @(negedge clk_pcie);
            for (int f = 0; f < NF; f++)
                if (int_ack[f]) obs_ack.push_back(f);
            if (auto_rdy) begin
                if (cfg_interrupt_rdy) begin
                    cfg_interrupt_rdy = 1'b0;
                    wait_cnt = 0;
                end else if (cfg_interrupt && !rdy_never) begin
                    wait_cnt++;
                    if (wait_cnt >= rdy_delay) begin
                        cfg_interrupt_rdy = 1'b1;
                        obs_hs.push_back({cfg_interrupt_assert, cfg_interrupt_di});
                        wait_cnt = 0;
                    end
                end else if (!cfg_interrupt) begin
                    wait_cnt = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_pcie);
        rst = 1'b0;
        @(negedge clk_pcie);
    endtask

    task automatic clear_queues();
        exp_hs.delete();
        obs_hs.delete();
        exp_ack.delete();
        obs_ack.delete();
    endtask

    task automatic wait_done(input int n_acks, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_pcie);
            if (obs_ack.size() >= n_acks && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int_enable = 1'b1;
        func_int_en = '1;
        int_req = '0;
        cfg_interrupt_msienable = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk_pcie);
        n_checks++;
        if ({int_ack, cfg_interrupt, cfg_interrupt_assert, cfg_interrupt_di, busy, timeout_err} !== 14'h0)
            $display("[TB] FAIL reset_held: outputs %h, expected all 0", {int_ack, cfg_interrupt, cfg_interrupt_assert, cfg_interrupt_di, busy, timeout_err});
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk_pcie);
        n_checks++;
        if ({int_ack, cfg_interrupt, busy, timeout_err} !== 5'h0)
            $display("[TB] FAIL reset_released: outputs %h, expected 0 with no requests", {int_ack, cfg_interrupt, busy, timeout_err});
        else n_pass++;
    endtask

    task automatic test_single_intx();
        int hi_seen;
        int idle_seen;
        clear_queues();
        auto_rdy = 1'b1;
        rdy_delay = 1;
        @(negedge clk_pcie); int_req = 2'b01;
        @(negedge clk_pcie); int_req = 2'b00;
        @(negedge clk_pcie);
        n_checks++;
        if ({cfg_interrupt, cfg_interrupt_assert, cfg_interrupt_di, busy} !== {1'b1, 1'b1, 8'h00, 1'b1})
            $display("[TB] FAIL single_assert: got int=%b assert=%b di=%h busy=%b, expected 1 1 00 1", cfg_interrupt, cfg_interrupt_assert, cfg_interrupt_di, busy);
        else n_pass++;
        @(negedge clk_pcie);
        n_checks++;
        if ({int_ack, cfg_interrupt} !== {2'b01, 1'b0})
            $display("[TB] FAIL single_ack: got ack=%b int=%b, expected 01 0", int_ack, cfg_interrupt);
        else n_pass++;
        hi_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_pcie);
            if (cfg_interrupt) hi_seen++;
        end
        n_checks++;
        if (hi_seen !== 0) $display("[TB] FAIL single_holdoff: int high %0d cycles during holdoff, expected 0", hi_seen);
        else n_pass++;
        @(negedge clk_pcie);
        n_checks++;
        if ({cfg_interrupt, cfg_interrupt_assert, cfg_interrupt_di} !== {1'b1, 1'b0, 8'h00})
            $display("[TB] FAIL single_deassert: got int=%b assert=%b di=%h, expected 1 0 00", cfg_interrupt, cfg_interrupt_assert, cfg_interrupt_di);
        else n_pass++;
        @(negedge clk_pcie);
        n_checks++;
        if ({cfg_interrupt, busy} !== 2'b01)
            $display("[TB] FAIL single_gap_start: got int=%b busy=%b, expected 0 1", cfg_interrupt, busy);
        else n_pass++;
        idle_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_pcie);
            if (!busy) idle_seen++;
        end
        n_checks++;
        if (idle_seen !== 0) $display("[TB] FAIL single_gap_len: busy low %0d cycles early, expected 0", idle_seen);
        else n_pass++;
        @(negedge clk_pcie);
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL single_idle: busy=%b, expected 0 after gap", busy);
        else n_pass++;
        n_checks++;
        if (obs_ack.size() !== 1) $display("[TB] FAIL single_ack_count: got %0d acks, expected 1", obs_ack.size());
        else n_pass++;
    endtask

    task automatic test_both_requests();
        bit ok;
        logic [8:0] e, o;
        int ea, oa;
        apply_reset();
        clear_queues();
        rdy_delay = 2;
        exp_hs.push_back({1'b1, 8'h00});
        exp_hs.push_back({1'b0, 8'h00});
        exp_hs.push_back({1'b1, 8'h01});
        exp_hs.push_back({1'b0, 8'h01});
        exp_ack.push_back(0);
        exp_ack.push_back(1);
        @(negedge clk_pcie); int_req = 2'b11;
        @(negedge clk_pcie); int_req = 2'b00;
        wait_done(2, 400, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL both_done: not idle with 2 acks after 400 cycles, got %0d acks", obs_ack.size());
        else n_pass++;
        n_checks++;
        if (obs_hs.size() !== exp_hs.size()) $display("[TB] FAIL both_hs_count: got %0d handshakes, expected %0d", obs_hs.size(), exp_hs.size());
        else n_pass++;
        while (exp_hs.size() > 0 && obs_hs.size() > 0) begin
            e = exp_hs.pop_front();
            o = obs_hs.pop_front();
            n_checks++;
            if (o !== e) $display("[TB] FAIL both_hs: got assert/di %h, expected %h", o, e);
            else n_pass++;
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front();
            oa = obs_ack.pop_front();
            n_checks++;
            if (oa !== ea) $display("[TB] FAIL both_ack_order: got ack %0d, expected %0d", oa, ea);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int got, ea;
        clear_queues();
        exp_ack.push_back(0);
        exp_ack.push_back(1);
        @(negedge clk_pcie); int_req = 2'b11;
        @(negedge clk_pcie); int_req = 2'b00;
        for (int k = 0; k < 6; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                if (obs_ack.size() > 0) begin ok = 1'b1; break; end
                @(negedge clk_pcie);
            end
            n_checks++;
            if (!ok) begin
                $display("[TB] FAIL rr_wait: no ack %0d within 200 cycles, expected ack %0d", k, exp_ack[0]);
                break;
            end
            got = obs_ack.pop_front();
            ea = exp_ack.pop_front();
            if (got !== ea) $display("[TB] FAIL rr_order: ack %0d was function %0d, expected %0d", k, got, ea);
            else n_pass++;
            if (k < 4) begin
                @(negedge clk_pcie); int_req = NF'(1 << got);
                exp_ack.push_back(got);
                @(negedge clk_pcie); int_req = 2'b00;
            end
        end
        wait_done(0, 200, ok);
        n_checks++;
        if (!ok || obs_ack.size() !== 0) $display("[TB] FAIL rr_drain: idle=%b extra acks=%0d, expected 1 0", ok, obs_ack.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        int hi;
        bit ok;
        int got;
        clear_queues();
        rdy_never = 1'b1;
        @(negedge clk_pcie); int_req = 2'b01;
        @(negedge clk_pcie); int_req = 2'b00;
        @(negedge clk_pcie);
        hi = 0;
        while (cfg_interrupt && hi < 2000) begin
            hi++;
            @(negedge clk_pcie);
        end
        n_checks++;
        if (hi !== 1024) $display("[TB] FAIL tmo_len: int held %0d cycles, expected 1024", hi);
        else n_pass++;
        n_checks++;
        if ({timeout_err, cfg_interrupt} !== 2'b10) $display("[TB] FAIL tmo_pulse: got err=%b int=%b, expected 1 0", timeout_err, cfg_interrupt);
        else n_pass++;
        n_checks++;
        if (obs_ack.size() !== 0) $display("[TB] FAIL tmo_no_ack: got %0d acks, expected 0", obs_ack.size());
        else n_pass++;
        @(negedge clk_pcie);
        n_checks++;
        if (timeout_err !== 1'b0) $display("[TB] FAIL tmo_one_cycle: err=%b, expected 0", timeout_err);
        else n_pass++;
        rdy_never = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_pcie);
            if (obs_ack.size() > 0) begin ok = 1'b1; break; end
        end
        got = ok ? obs_ack.pop_front() : -1;
        n_checks++;
        if (got !== 0) $display("[TB] FAIL tmo_retry: retried ack function %0d, expected 0", got);
        else n_pass++;
        wait_done(0, 200, ok);
    endtask

    task automatic test_enable_and_reset();
        int seen;
        int lat;
        func_int_en = 2'b01;
        clear_queues();
        @(negedge clk_pcie); int_req = 2'b10;
        @(negedge clk_pcie); int_req = 2'b00;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_pcie);
            if (busy || cfg_interrupt) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("[TB] FAIL en_blocked: activity on %0d cycles while disabled, expected 0", seen);
        else n_pass++;
        rdy_never = 1'b1;
        func_int_en = 2'b11;
        lat = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_pcie);
            if (cfg_interrupt) begin lat = i; break; end
        end
        n_checks++;
        if (lat < 1 || lat > 2) $display("[TB] FAIL en_grant_latency: grant after %0d cycles, expected 1..2", lat);
        else n_pass++;
        n_checks++;
        if ({cfg_interrupt_assert, cfg_interrupt_di} !== {1'b1, 8'h01})
            $display("[TB] FAIL en_grant_idx: got assert=%b di=%h, expected 1 01", cfg_interrupt_assert, cfg_interrupt_di);
        else n_pass++;
        repeat (5) @(negedge clk_pcie);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({cfg_interrupt, cfg_interrupt_assert, cfg_interrupt_di, busy} !== 11'h0)
            $display("[TB] FAIL rst_async: got int=%b assert=%b di=%h busy=%b, expected all 0", cfg_interrupt, cfg_interrupt_assert, cfg_interrupt_di, busy);
        else n_pass++;
        @(negedge clk_pcie);
        rst = 1'b0;
        rdy_never = 1'b0;
        repeat (3) @(negedge clk_pcie);
        n_checks++;
        if ({cfg_interrupt, busy} !== 2'b00) $display("[TB] FAIL rst_pending_cleared: int=%b busy=%b, expected 0 0", cfg_interrupt, busy);
        else n_pass++;
    endtask

    task automatic test_msi();
        bit ok;
        logic [8:0] e, o;
        int oa;
        clear_queues();
        cfg_interrupt_msienable = 1'b1;
`ifdef PCIE_INT_ARB_MSI_EN
        exp_hs.push_back({1'b0, 8'h01});
`else
        exp_hs.push_back({1'b1, 8'h01});
        exp_hs.push_back({1'b0, 8'h01});
`endif
        exp_ack.push_back(1);
        @(negedge clk_pcie); int_req = 2'b10;
        @(negedge clk_pcie); int_req = 2'b00;
        wait_done(1, 200, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL msi_done: not idle with ack after 200 cycles, got %0d acks", obs_ack.size());
        else n_pass++;
        n_checks++;
        if (obs_hs.size() !== exp_hs.size()) $display("[TB] FAIL msi_hs_count: got %0d handshakes, expected %0d", obs_hs.size(), exp_hs.size());
        else n_pass++;
        while (exp_hs.size() > 0 && obs_hs.size() > 0) begin
            e = exp_hs.pop_front();
            o = obs_hs.pop_front();
            n_checks++;
            if (o !== e) $display("[TB] FAIL msi_hs: got assert/di %h, expected %h", o, e);
            else n_pass++;
        end
        oa = (obs_ack.size() > 0) ? obs_ack.pop_front() : -1;
        n_checks++;
        if (oa !== exp_ack[0]) $display("[TB] FAIL msi_ack: got ack function %0d, expected %0d", oa, exp_ack[0]);
        else n_pass++;
        cfg_interrupt_msienable = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        int_enable = 1'b0;
        func_int_en = '0;
        int_req = '0;
        cfg_interrupt_msienable = 1'b0;
        test_reset();
        test_single_intx();
        test_both_requests();
        test_round_robin();
        test_timeout();
        test_enable_and_reset();
        test_msi();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
